timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped programmable timer/counter on the CPU's data-memory side, downstream of the pipeline's MEM stage through the system bridge. It exposes three word registers (CTRL, PRESET, COUNT) and counts down from a preset value. On expiry it raises an interrupt request for the CP0/exception logic, either once or periodically with auto-reload.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high; clears all state
- addr  input  32  byte address from bridge; only addr[3:2] decoded
- we  input  1  write strobe, qualified by bridge chip-select
- wdata  input  32  write data
- rdata  output  32  read data, combinational from addr[3:2]
- irq  output  1  interrupt request, registered-state derived

## Operation
- Register map (addr[3:2]):
  - 0 CTRL: [0] EN, [2:1] MODE, [3] IM; other bits read 0.
  - 1 PRESET: 32-bit reload value.
  - 2 COUNT: read-only.
  - 3: reads 0; writes ignored.
- Writes to COUNT are ignored.
- MODE 00 = one-shot, 01 = auto-reload; 10/11 behave as 00.
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT<=PRESET; -> CNT.
  - CNT:
    - EN=0 -> IDLE, COUNT held.
    - COUNT>1 -> COUNT-1.
    - COUNT==1 -> COUNT<=0, -> INT.
    - COUNT==0 (PRESET 0) -> INT.
  - INT:
    - MODE 00: EN cleared, IRQ flag set, -> IDLE.
    - MODE 01: flag asserted for this cycle only, -> LOAD.
- irq = flag & IM.
  - One-shot flag is sticky, cleared by any CTRL write.
  - Auto-reload irq is a one-cycle pulse while state==INT.
- COUNT arithmetic is 32-bit unsigned; no wrap below 0.
- PRESET written during CNT affects only the next LOAD.
- Bus write to CTRL at the same edge the FSM clears EN: bus write wins.
- Reset mid-count: everything returns to reset values on that edge.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, flag 0, irq 0. rdata reflects these combinationally.
- Writes take effect at the rising edge where we=1; reads see the new value in the next cycle.
- Timeline for PRESET=N≥1, EN written at edge E:
  - LOAD at E+1.
  - COUNT=N at E+2.
  - COUNT=0 and state INT at E+2+N.
  - One-shot irq high from E+2+N until a CTRL write.
- Auto-reload period: N+2 cycles between irq pulses. Pulse at E+2+N, reload LOAD->CNT, next pulse at E+2+2N+2.
- Clearing EN during CNT freezes COUNT from the next edge.

## Configuration
- TC_AUTO_RELOAD_EN defined: MODE 01 behaves as above.
- Not defined: MODE bits still stored and readable, but every mode behaves as one-shot; INT always goes to IDLE.

## Structure
- Shared header holds:
  - register offsets (CTRL/PRESET/COUNT word indices)
  - CTRL bit positions
  - MODE encodings
  - FSM state encodings
- One natural sub-module, tc_ctrl_fsm: state register, next-state logic, COUNT decrement, flag. The top keeps the register file, address decode and read mux.

## Test plan
- Reset then read all three offsets: rdata=0 each, irq=0.
- PRESET=5, CTRL=0x9 (EN, IM, one-shot): irq rises 7 edges after CTRL write, COUNT=0, CTRL reads 0x8. A CTRL write clears irq next cycle.
- PRESET=3, CTRL=0xB (auto-reload, IM): irq one-cycle pulses every 5 cycles; COUNT cycles 3,2,1,0.
- PRESET=0, CTRL=0x9: irq high 3 edges after write.
- PRESET=10, enable, write CTRL=0x8 after 4 edges: COUNT frozen at 8, irq stays 0. Rewrite PRESET=2 and re-enable: irq 4 edges later.
- Assert reset while COUNT=4 in CNT: next cycle all registers 0, irq 0. Write to offset 3 and to COUNT: no effect.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer_counter block: register word indices,
// CTRL bit positions, MODE encodings and FSM state encodings.
package timer_counter_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/timer_counter_fsm.sv
// Timer sequencer tc_ctrl_fsm: IDLE/LOAD/CNT/INT state, COUNT down-counter
// and the interrupt flag (sticky for one-shot, single cycle for auto-reload).
module tc_ctrl_fsm
    import timer_counter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        auto_reload,
    input  logic [31:0] preset,
    input  logic        flag_clr,
    output logic [31:0] count,
    output logic        flag,
    output logic [1:0]  state
);

    logic sticky;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: if (en) state <= ST_LOAD;
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        // Covers both the last tick and a zero preset.
                        count <= 32'd0;
                        state <= ST_INT;
                    end
                end
                ST_INT:  state <= auto_reload ? ST_LOAD : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A CTRL write clearing the flag wins over a one-shot expiry on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky <= 1'b0;
        end else if (flag_clr) begin
            sticky <= 1'b0;
        end else if (state == ST_INT && !auto_reload) begin
            sticky <= 1'b1;
        end
    end

    assign flag = sticky | (state == ST_INT);

endmodule

// File: rtl/timer_counter.sv
// Memory-mapped timer/counter: CTRL/PRESET/COUNT registers around tc_ctrl_fsm.
// Auto-reload mode exists only when TC_AUTO_RELOAD_EN is defined.
module timer_counter
    import timer_counter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    ctrl_t       ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic [1:0]  idx;
    logic [1:0]  fsm_state;
    logic        flag;
    logic        ctrl_wr;
    logic        en_clr;
    logic        auto_reload;
    logic        unused_addr;

    assign idx         = addr[3:2];
    assign unused_addr = ^{addr[31:4], addr[1:0]};
    assign ctrl_wr     = we && (idx == REG_CTRL);

`ifdef TC_AUTO_RELOAD_EN
    assign auto_reload = (ctrl.mode == MODE_AUTO);
`else
    assign auto_reload = 1'b0;
`endif

    assign en_clr = (fsm_state == ST_INT) && !auto_reload;

    // Bus write to CTRL takes priority over the one-shot EN clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl   <= '0;
            preset <= 32'd0;
        end else begin
            if (ctrl_wr) begin
                ctrl.en   <= wdata[CTRL_EN];
                ctrl.mode <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
                ctrl.im   <= wdata[CTRL_IM];
            end else if (en_clr) begin
                ctrl.en <= 1'b0;
            end
            if (we && idx == REG_PRESET) preset <= wdata;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (idx)
            REG_CTRL: begin
                rdata[CTRL_EN]                   = ctrl.en;
                rdata[CTRL_MODE_HI:CTRL_MODE_LO] = ctrl.mode;
                rdata[CTRL_IM]                   = ctrl.im;
            end
            REG_PRESET: rdata = preset;
            REG_COUNT:  rdata = count;
            default:    rdata = 32'd0;
        endcase
    end

    tc_ctrl_fsm u_fsm (
        .clk         (clk),
        .reset       (reset),
        .en          (ctrl.en),
        .auto_reload (auto_reload),
        .preset      (preset),
        .flag_clr    (ctrl_wr),
        .count       (count),
        .flag        (flag),
        .state       (fsm_state)
    );

    assign irq = flag & ctrl.im;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: deadline-based reference model compared every cycle,
// plus directed scenarios with hand-computed latencies and register values.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    // Reference model: a run is described by the edge where COUNT is loaded
    // and the edge where it expires, rather than by explicit states.
    int          cyc = 0;
    logic [3:0]  m_ctrl = 4'd0;
    logic [31:0] m_preset = 32'd0;
    logic [31:0] m_count = 32'd0;
    bit          m_sticky = 1'b0;
    bit          m_busy = 1'b0;
    int          m_load_at = -1;
    int          m_exp_at = -1;

    function automatic bit model_auto();
`ifdef TC_AUTO_RELOAD_EN
        return m_ctrl[2:1] == 2'b01;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] idx);
        case (idx)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_irq();
        return m_ctrl[3] && (m_sticky || (m_busy && cyc == m_exp_at));
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0;
            m_sticky = 1'b0; m_busy = 1'b0; m_load_at = -1; m_exp_at = -1;
        end else begin
            bit en_clr;
            bit sticky_set;
            logic [31:0] n_count;
            en_clr = 1'b0;
            sticky_set = 1'b0;
            n_count = m_count;
            if (m_busy) begin
                if (cyc == m_load_at) begin
                    n_count = m_preset;
                    m_exp_at = cyc + ((m_preset == 32'd0) ? 1 : int'(m_preset));
                end else if (cyc <= m_exp_at) begin
                    if (!m_ctrl[0]) m_busy = 1'b0;
                    else if (m_count != 32'd0) n_count = m_count - 32'd1;
                end else if (model_auto()) begin
                    m_load_at = cyc + 1;
                end else begin
                    m_busy = 1'b0;
                    en_clr = 1'b1;
                    sticky_set = 1'b1;
                end
            end else if (m_ctrl[0]) begin
                m_busy = 1'b1;
                m_load_at = cyc + 1;
                m_exp_at = -1;
            end
            m_count = n_count;
            if (we && addr[3:2] == 2'd0) begin
                m_ctrl = wdata[3:0];
                m_sticky = 1'b0;
            end else begin
                if (en_clr) m_ctrl[0] = 1'b0;
                if (sticky_set) m_sticky = 1'b1;
            end
            if (we && addr[3:2] == 2'd1) m_preset = wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("irq_vs_model", {31'd0, irq}, {31'd0, model_irq()});
            check("rdata_vs_model", rdata, model_read(addr[3:2]));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [1:0] idx, input logic [31:0] data);
        addr = {28'd0, idx, 2'b00};
        wdata = data;
        we = 1'b1;
        @(posedge clk);
        #2;
        we = 1'b0;
        wdata = 32'd0;
        addr = 32'h8;
    endtask

    task automatic rd(input logic [1:0] idx, output logic [31:0] v);
        addr = {28'd0, idx, 2'b00};
        #1;
        v = rdata;
    endtask

    task automatic wait_irq(input int max, output int k);
        k = 0;
        while (k < max) begin
            @(posedge clk);
            #2;
            k++;
            if (irq) break;
        end
    endtask

    logic [31:0] v;
    int k;

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        chk_on = 1'b1;

        // Reset state
        rd(2'd0, v); check("reset_ctrl", v, 32'd0);
        rd(2'd1, v); check("reset_preset", v, 32'd0);
        idle(1);
        rd(2'd2, v); check("reset_count", v, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);

        // One-shot, PRESET=5
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        wait_irq(20, k);
        check("oneshot_latency", k, 32'd7);
        rd(2'd2, v); check("oneshot_count", v, 32'd0);
        idle(1);
        rd(2'd0, v); check("oneshot_ctrl", v, 32'h8);
        idle(3);
        check("oneshot_sticky", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'h8);
        check("oneshot_clear", {31'd0, irq}, 32'd0);

        // MODE 01, PRESET=3
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        wait_irq(20, k);
        check("mode01_first_latency", k, 32'd5);
`ifdef TC_AUTO_RELOAD_EN
        rd(2'd2, v); check("auto_count_at_pulse", v, 32'd0);
        idle(1);
        check("auto_pulse_width", {31'd0, irq}, 32'd0);
        wait_irq(20, k);
        check("auto_period_rest", k, 32'd4);
        idle(2);
        rd(2'd2, v); check("auto_reloaded_count", v, 32'd3);
`else
        idle(3);
        check("mode01_sticky", {31'd0, irq}, 32'd1);
        rd(2'd0, v); check("mode01_ctrl", v, 32'hA);
`endif
        wr(2'd0, 32'h0);
        idle(4);

        // PRESET=0
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        wait_irq(20, k);
        check("zero_preset_latency", k, 32'd3);
        wr(2'd0, 32'h0);
        check("zero_preset_clear", {31'd0, irq}, 32'd0);
        idle(2);

        // Freeze mid-count, then re-arm with a new preset
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        idle(3);
        wr(2'd0, 32'h8);
        idle(4);
        rd(2'd2, v); check("frozen_count", v, 32'd8);
        check("frozen_irq", {31'd0, irq}, 32'd0);
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        wait_irq(20, k);
        check("rearm_latency", k, 32'd4);
        wr(2'd0, 32'h0);
        idle(2);

        // Reset while counting
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        idle(8);
        rd(2'd2, v); check("pre_reset_count", v, 32'd4);
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        rd(2'd0, v); check("midreset_ctrl", v, 32'd0);
        rd(2'd1, v); check("midreset_preset", v, 32'd0);
        check("midreset_irq", {31'd0, irq}, 32'd0);
        idle(1);
        rd(2'd2, v); check("midreset_count", v, 32'd0);

        // Ignored writes and reserved CTRL bits
        wr(2'd3, 32'hDEADBEEF);
        wr(2'd2, 32'h00001234);
        rd(2'd3, v); check("offset3_reads_zero", v, 32'd0);
        rd(2'd2, v); check("count_write_ignored", v, 32'd0);
        idle(1);
        rd(2'd0, v); check("offset3_no_ctrl_effect", v, 32'd0);
        wr(2'd0, 32'hFFFF_FFF0);
        rd(2'd0, v); check("ctrl_reserved_bits", v, 32'd0);
        idle(3);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
